mult_switch_multibuf: RTL and testbench
=======================================

# mult_switch_multibuf

Parametrised multiplier switch for the distribution/reduction fabric: holds up to DEPTH stationary operands in a local buffer and multiplies each streaming operand against an entry chosen per-beat by a select index. Products leave through a fixed-latency pipeline toward the reduction network, with per-entry valid tracking, bulk clear and drop signalling. It generalises the single-entry, fixed-width multiplier switch to several stationary operands per switch, configurable width and latency, and an optional local accumulation mode.

## Interface
- DATA_W, 16, operand width, signed two's complement
- DEPTH, 4, stationary buffer entries (>= 1)
- SEL_W, 2, index width, ceil(log2(DEPTH)), minimum 1
- LATENCY, 2, cycles from accepted streaming beat to o_valid (>= 1)
- GUARD_W, 8, accumulator guard bits; OUT_W = 2*DATA_W + GUARD_W
- clk  input  1  clock
- rst  input  1  reset; one clock, synchronous, active-high
- i_valid  input  1  beat valid
- i_data  input  DATA_W  operand
- i_stationary  input  1  1: beat loads buffer; 0: beat streams
- i_sel  input  SEL_W  buffer entry used by a streaming beat
- i_clear  input  1  invalidate all entries, rewind write pointer
- i_last  input  1  last beat of a dot-product group (accumulation only)
- o_valid  output  1  result valid
- o_data  output  OUT_W  signed result
- o_drop  output  1  one-cycle pulse: streaming beat discarded
- o_full  output  1  all DEPTH entries valid

## Operation
- Load: i_valid & i_stationary writes i_data to buf[wr_ptr], sets ent_valid[wr_ptr], increments wr_ptr mod DEPTH (wraps to 0; overwrites oldest entry when full, no stall).
- Stream: i_valid & !i_stationary with i_sel < DEPTH and ent_valid[i_sel] = 1 -> signed product i_data * buf[i_sel] (2*DATA_W bits) enters pipeline.
- Otherwise (entry invalid or i_sel >= DEPTH) -> beat discarded, o_drop = 1 next cycle, nothing enters pipeline.
- Without accumulation: o_data = product sign-extended to OUT_W.
- Clear: i_clear -> all ent_valid = 0, wr_ptr = 0 next cycle; beats already in the pipeline still complete. i_clear has priority over a same-cycle load (the load is lost). A same-cycle stream is evaluated against pre-clear state.
- Same-cycle load and stream impossible (single i_stationary); a stream in the cycle after a load to that entry sees the new value.
- o_full = &ent_valid, registered.
- i_valid = 0: i_data, i_sel, i_last ignored.

## Timing
- Reset: o_valid = 0, o_data = 0, o_drop = 0, o_full = 0, wr_ptr = 0, all ent_valid = 0, all pipeline valid bits = 0, accumulator = 0. Reset mid-operation kills all in-flight beats; no stale o_valid afterwards.
- Stream accepted at cycle t -> o_valid at t+LATENCY, one result per cycle, fully pipelined, in order, no backpressure.
- Load at t -> entry usable by a stream at t+1; o_full updates at t+1.
- o_drop at t+1 for a beat discarded at t.
- o_data holds its last value when o_valid = 0.

## Configuration
- MULT_SWITCH_ACC_EN defined: final pipeline stage accumulates. Each completing product is added to a signed OUT_W accumulator (wraps mod 2^OUT_W). o_valid asserts only for the product carrying i_last = 1, with o_data = accumulator + that product; accumulator then returns to 0. Non-last products give o_valid = 0. Latency stays LATENCY. i_clear does not touch the accumulator; rst zeroes it.
- Undefined: i_last ignored, no accumulator logic, every accepted stream produces o_valid.

## Test plan
- Load 3, -5, 7, 2 into entries 0..3 -> o_full = 1 one cycle after the fourth load; stream i_data = 4 with i_sel = 1 -> o_valid exactly LATENCY cycles later, o_data = -20 sign-extended.
- After reset, stream i_sel = 0 -> o_drop pulse at t+1, o_valid never asserts; with DEPTH = 3, i_sel = 3 -> drop.
- Fifth load value 9 after four loads -> overwrites entry 0; stream 2 with i_sel = 0 -> 18.
- i_clear together with a load -> all entries invalid, wr_ptr = 0, load lost; in-flight products from the preceding two cycles still emerge; a following stream -> drop.
- Back-to-back streams 1..8 against entry value 3 -> 8 consecutive o_valid cycles, 3..24 in order; assert rst mid-burst -> o_valid = 0 from the next cycle, no later results.
- MULT_SWITCH_ACC_EN: entry = 2, stream 1, 2, 3 with i_last on 3 -> single o_valid, o_data = 12; next group of 5 (last) -> 10; DATA_W = 16 with -32768 * -32768 -> 2^30, no truncation.

Source files
------------

// File: rtl/mult_switch_multibuf.sv
// mult_switch_multibuf
//   Multiplier switch with a small stationary-operand buffer. Stationary
//   beats fill the buffer round-robin. Each streaming beat multiplies its
//   operand by the buffer entry that i_sel picks. The product leaves after a
//   fixed LATENCY toward the reduction network.
//
//   Optional feature macro: MULT_SWITCH_ACC_EN. When it is defined, the final
//   stage accumulates products locally. Only the group-closing product
//   (i_last) then raises o_valid.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   i_valid       beat valid
//   i_data        signed operand (DATA_W)
//   i_stationary  1: load i_data into the buffer, 0: stream against i_sel
//   i_sel         buffer entry used by a streaming beat
//   i_clear       invalidate all entries and rewind the write pointer
//   i_last        closes a dot-product group (accumulation build only)
//   o_valid       result valid
//   o_data        signed result (OUT_W = 2*DATA_W + GUARD_W)
//   o_drop        one-cycle pulse: a streaming beat hit an invalid entry
//   o_full        every buffer entry holds a valid operand
module mult_switch_multibuf #(
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 4,
   parameter int SEL_W   = 2,
   parameter int LATENCY = 2,
   parameter int GUARD_W = 8,
   localparam int OUT_W  = 2*DATA_W + GUARD_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   input  logic signed [DATA_W-1:0] i_data,
   input  logic                     i_stationary,
   input  logic [SEL_W-1:0]         i_sel,
   input  logic                     i_clear,
   input  logic                     i_last,
   output logic                     o_valid,
   output logic signed [OUT_W-1:0]  o_data,
   output logic                     o_drop,
   output logic                     o_full
);

   localparam int PROD_W = 2*DATA_W;
   localparam logic [SEL_W:0]   DEPTH_V  = (SEL_W+1)'(DEPTH);
   localparam logic [SEL_W-1:0] LAST_PTR = SEL_W'(DEPTH-1);

   function automatic logic signed [OUT_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
      return {{GUARD_W{p[PROD_W-1]}}, p};
   endfunction

   logic signed [DATA_W-1:0] stat_mem [DEPTH];
   logic [DEPTH-1:0]         ent_valid, ent_valid_nxt;
   logic [SEL_W-1:0]         wr_ptr, wr_ptr_nxt;

   logic                     load, stream, sel_ok, hit, drop_c;
   logic signed [PROD_W-1:0] prod_c;

   logic                     fin_vld, fin_last;
   logic signed [PROD_W-1:0] fin_prod;

   // Input stage: buffer lookup and multiply, evaluated against the
   // pre-clear buffer state.
   always_comb begin
      load   = i_valid & i_stationary;
      stream = i_valid & ~i_stationary;
      sel_ok = ({1'b0, i_sel} < DEPTH_V);
      hit    = stream & sel_ok & ent_valid[i_sel];
      drop_c = stream & ~hit;
      prod_c = stat_mem[i_sel] * i_data;
   end

   // A clear wins over a load in the same cycle, so that load is lost.
   always_comb begin
      ent_valid_nxt = ent_valid;
      wr_ptr_nxt    = wr_ptr;
      if (i_clear) begin
         ent_valid_nxt = '0;
         wr_ptr_nxt    = '0;
      end else if (load) begin
         ent_valid_nxt[wr_ptr] = 1'b1;
         wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + SEL_W'(1);
      end
   end

   // o_full is registered from the next-state vector, so it reflects a load
   // in the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ent_valid <= '0;
         wr_ptr    <= '0;
         o_full    <= 1'b0;
         o_drop    <= 1'b0;
      end else begin
         ent_valid <= ent_valid_nxt;
         wr_ptr    <= wr_ptr_nxt;
         o_full    <= &ent_valid_nxt;
         o_drop    <= drop_c;
      end
   end

   always_ff @(posedge clk) begin
      if (load && !i_clear)
         stat_mem[wr_ptr] <= i_data;
   end

   // Delay stages p0..p(LATENCY-2). The output register supplies the final
   // cycle of latency.
   generate
      if (LATENCY > 1) begin : g_pipe
         localparam int PIPE_N = LATENCY - 1;
         logic                     vld_p  [PIPE_N];
         logic                     last_p [PIPE_N];
         logic signed [PROD_W-1:0] prod_p [PIPE_N];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < PIPE_N; k++) vld_p[k] <= 1'b0;
            end else begin
               vld_p[0] <= hit;
               for (int k = 1; k < PIPE_N; k++) vld_p[k] <= vld_p[k-1];
            end
         end

         always_ff @(posedge clk) begin
            prod_p[0] <= prod_c;
            last_p[0] <= i_last;
            for (int k = 1; k < PIPE_N; k++) begin
               prod_p[k] <= prod_p[k-1];
               last_p[k] <= last_p[k-1];
            end
         end

         assign fin_vld  = vld_p[PIPE_N-1];
         assign fin_prod = prod_p[PIPE_N-1];
         assign fin_last = last_p[PIPE_N-1];
      end else begin : g_nopipe
         assign fin_vld  = hit;
         assign fin_prod = prod_c;
         assign fin_last = i_last;
      end
   endgenerate

   // Output stage: o_data keeps its last value while o_valid is low.
`ifdef MULT_SWITCH_ACC_EN
   logic signed [OUT_W-1:0] acc, acc_sum;

   assign acc_sum = acc + sext_prod(fin_prod);

   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         acc     <= '0;
      end else begin
         o_valid <= fin_vld & fin_last;
         if (fin_vld) begin
            if (fin_last) begin
               o_data <= acc_sum;
               acc    <= '0;
            end else begin
               acc    <= acc_sum;
            end
         end
      end
   end
`else
   logic unused_fin_last;
   assign unused_fin_last = fin_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         o_valid <= fin_vld;
         if (fin_vld)
            o_data <= sext_prod(fin_prod);
      end
   end
`endif

endmodule

// File: tb/tb_mult_switch_multibuf.sv
// Scoreboard bench for mult_switch_multibuf. The stimulus tasks push the
// expected results and drop pulses, each with the cycle it is due in. A
// negedge monitor pops and compares them. A second DEPTH=3 instance shares
// the stimulus. It is used only to check the out-of-range select.
module tb_mult_switch_multibuf;

   localparam int LAT   = 2;
   localparam int OUT_W = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_valid = 1'b0, i_stationary = 1'b0, i_clear = 1'b0, i_last = 1'b0;
   logic signed [15:0] i_data = '0;
   logic [1:0] i_sel = '0;

   logic o_valid, o_drop, o_full;
   logic signed [OUT_W-1:0] o_data;
   logic o3_valid, o3_drop, o3_full;
   logic signed [OUT_W-1:0] o3_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic signed [OUT_W-1:0] exp_val_q [$];
   int exp_cyc_q [$];
   int exp_drop_q [$];

   mult_switch_multibuf #(.DATA_W(16), .DEPTH(4), .SEL_W(2), .LATENCY(LAT), .GUARD_W(8)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
      .i_stationary(i_stationary), .i_sel(i_sel), .i_clear(i_clear), .i_last(i_last),
      .o_valid(o_valid), .o_data(o_data), .o_drop(o_drop), .o_full(o_full));

   mult_switch_multibuf #(.DATA_W(16), .DEPTH(3), .SEL_W(2), .LATENCY(LAT), .GUARD_W(8)) dut3 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
      .i_stationary(i_stationary), .i_sel(i_sel), .i_clear(i_clear), .i_last(i_last),
      .o_valid(o3_valid), .o_data(o3_data), .o_drop(o3_drop), .o_full(o3_full));

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: compare every presented result and drop pulse with the queues.
   always @(negedge clk) begin
      if (o_valid) begin
         if (exp_val_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual=%0d required=no result (cycle %0d)",
                     longint'(o_data), cyc);
         end else begin
            chk("result_data", longint'(o_data), longint'(exp_val_q.pop_front()));
            chk("result_cycle", cyc, exp_cyc_q.pop_front());
         end
      end
      if (o_drop) begin
         if (exp_drop_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_drop actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            chk("drop_cycle", cyc, exp_drop_q.pop_front());
         end
      end
   end

   task automatic drive(input logic st, input longint d, input logic [1:0] sel,
                        input logic clr, input logic last);
      i_valid = 1'b1; i_stationary = st; i_data = 16'(d); i_sel = sel;
      i_clear = clr; i_last = last;
      @(posedge clk); #1;
      i_valid = 1'b0; i_stationary = 1'b0; i_data = '0; i_sel = '0;
      i_clear = 1'b0; i_last = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic load(input longint d);
      drive(1'b1, d, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic stream_hit(input longint d, input logic [1:0] sel, input longint req,
                             input logic last);
      exp_val_q.push_back(OUT_W'(req));
      exp_cyc_q.push_back(cyc + LAT);
      drive(1'b0, d, sel, 1'b0, last);
   endtask

   task automatic stream_drop(input longint d, input logic [1:0] sel);
      exp_drop_q.push_back(cyc + 1);
      drive(1'b0, d, sel, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_val_q.delete();
      exp_cyc_q.delete();
      exp_drop_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      chk("reset_o_valid", o_valid, 0);
      chk("reset_o_data", o_data, 0);
      chk("reset_o_drop", o_drop, 0);
      chk("reset_o_full", o_full, 0);

`ifdef MULT_SWITCH_ACC_EN
      load(2);
      drive(1'b0, 1, 2'd0, 1'b0, 1'b0);
      drive(1'b0, 2, 2'd0, 1'b0, 1'b0);
      stream_hit(3, 2'd0, 12, 1'b1);
      stream_hit(5, 2'd0, 10, 1'b1);
      load(-32768);
      stream_hit(-32768, 2'd1, 1073741824, 1'b1);
      stream_drop(1, 2'd3);
      drive(1'b0, -3, 2'd0, 1'b0, 1'b0);
      drive(1'b0, -32768, 2'd1, 1'b0, 1'b0);
      stream_hit(-32768, 2'd1, 2147483642, 1'b1);
`else
      // Streaming into an empty buffer drops the beat.
      stream_drop(5, 2'd0);
      load(3); load(-5); load(7);
      chk("dut3_full_after_3_loads", o3_full, 1);
      chk("full_after_3_loads", o_full, 0);
      // Entry 3 is invalid here. In the DEPTH=3 instance, select 3 is out of range.
      stream_drop(1, 2'd3);
      chk("dut3_drop_sel_out_of_range", o3_drop, 1);
      stream_hit(4, 2'd2, 28, 1'b0);
      idle(1);
      chk("dut3_valid", o3_valid, 1);
      chk("dut3_data", longint'(o3_data), 28);
      load(2);
      chk("full_after_4_loads", o_full, 1);
      stream_hit(4, 2'd1, -20, 1'b0);
      // A fifth load wraps onto entry 0. A stream in the next cycle sees the new value.
      load(9);
      stream_hit(2, 2'd0, 18, 1'b0);
      chk("full_after_wrap", o_full, 1);
      // The pointer is now 1; load 3 there and run a back-to-back burst.
      load(3);
      for (int k = 1; k <= 8; k++) stream_hit(k, 2'd1, 3*k, 1'b0);
      stream_hit(-32768, 2'd2, -229376, 1'b0);
      stream_hit(-1, 2'd3, -2, 1'b0);
      // The clear also carries a load. Both products already in flight still complete.
      stream_hit(10, 2'd1, 30, 1'b0);
      stream_hit(-1, 2'd3, -2, 1'b0);
      drive(1'b1, 11, 2'd0, 1'b1, 1'b0);
      chk("full_after_clear", o_full, 0);
      stream_drop(3, 2'd1);
      load(6);
      stream_hit(2, 2'd0, 12, 1'b0);
      stream_drop(1, 2'd1);
      // A reset in the middle of a burst kills the beats still in flight.
      load(3);
      for (int k = 1; k <= 4; k++) stream_hit(k, 2'd1, 3*k, 1'b0);
      do_reset();
      chk("midreset_o_valid", o_valid, 0);
      chk("midreset_o_data", o_data, 0);
      chk("midreset_o_full", o_full, 0);
      idle(5);
      stream_drop(1, 2'd0);
`endif

      for (int i = 0; i < 20; i++) begin
         if (exp_val_q.size() == 0 && exp_drop_q.size() == 0) break;
         idle(1);
      end
      idle(3);
      chk("pending_results", exp_val_q.size(), 0);
      chk("pending_drops", exp_drop_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
